// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the widest supported operand width.
package serial_pkg;

  localparam int SERIAL_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared by the serial arithmetic blocks.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: diff = a + ~b + 1, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic w_sum;
  logic w_co;
  logic w_last;

  full_adder u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .cin   (r_c),
    .sum   (w_sum),
    .carry (w_co)
  );

  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_c      <= 1'b1;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + 1: invert b here, carry-in of 1 supplies the +1.
            r_a_sh  <= a;
            r_b_sh  <= ~b;
            r_c     <= 1'b1;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res  <= {w_sum, r_res[WIDTH-1:1]};
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_c    <= w_co;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff   <= {w_sum, r_res[WIDTH-1:1]};
            r_borrow <= ~w_co;
`ifdef SERIAL_SUB_OVF_EN
            // r_c is the carry into the MSB during this final bit.
            r_ovf    <= r_c ^ w_co;
`endif
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus random testbench for serial_subtractor (WIDTH=8).
// Honours SERIAL_SUB_OVF_EN to connect and check the ovf output.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .borrow    (borrow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid after an accept edge; returns number of edges waited.
  task automatic wait_result(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 4 * W);
  endtask

  // Reference model: plain modular arithmetic and signed-range reasoning.
  task automatic check_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
    int unsigned ua;
    int unsigned ub;
    int          sa;
    int          sb;
    int          sd;
    ua = ea;
    ub = eb;
    sa = (ua >= 128) ? int'(ua) - 256 : int'(ua);
    sb = (ub >= 128) ? int'(ub) - 256 : int'(ub);
    sd = sa - sb;
    check({tag, "_valid"},  32'(out_valid), 32'd1);
    check({tag, "_diff"},   32'(diff), (ua - ub + 256) % 256);
    check({tag, "_borrow"}, 32'(borrow), (ua < ub) ? 32'd1 : 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"},    32'(ovf), (sd > 127 || sd < -128) ? 32'd1 : 32'd0);
`else
    if (sd == 9999) $display("unreachable");
`endif
  endtask

  // Full transaction with out_ready high: accept, latency, result, return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
    int n;
    check({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ea;
    b = eb;
    tick();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_result(n);
    check({tag, "_latency"}, n, W);
    check_result(tag, ea, eb);
    check({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'd0);
    check("rst_borrow",    32'(borrow),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("t1", 8'd10, 8'd3);
    run_op("t2a", 8'd3, 8'd10);
    run_op("t2b", 8'h5A, 8'h5A);
    run_op("zero", 8'h00, 8'h00);
    run_op("t3a", 8'h80, 8'h01);
    run_op("t3b", 8'h05, 8'h03);
    run_op("edge", 8'h00, 8'hFF);
    run_op("edge2", 8'h7F, 8'h80);

    // Back-pressure: result held while out_ready is low.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 8'd77;
    b = 8'd99;
    tick();
    in_valid = 1'b0;
    wait_result(n);
    check("bp_latency", n, W);
    check_result("bp", 8'd77, 8'd99);
    held = diff;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_diff_hold",  32'(diff), 32'(held));
      check("bp_in_ready",   32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // in_valid held high with new operands during RUN must be ignored.
    in_valid = 1'b1;
    a = 8'd40;
    b = 8'd15;
    tick();
    a = 8'd9;
    b = 8'd250;
    tick();
    check("ign_in_ready", 32'(in_ready), 32'd0);
    wait_result(n);
    check("ign_latency", n, W - 1);
    check_result("ign_first", 8'd40, 8'd15);
    tick();
    check("ign_idle_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_result(n);
    check("ign_second_latency", n, W);
    check_result("ign_second", 8'd9, 8'd250);
    tick();

    // Reset in the middle of RUN discards the operation.
    in_valid = 1'b1;
    a = 8'd123;
    b = 8'd45;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    check("mrst_in_ready",  32'(in_ready),  32'd1);
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_diff",      32'(diff),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("mrst_no_valid", 32'(out_valid), 32'd0);
    run_op("t6", 8'd200, 8'd55);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op("rand", ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
